// File: rtl/stage4_mem.sv
// MEM stage plus MEM/WB register: branch resolution and a req/ready data-memory access that stalls the pipe.
// Latency: 1 cycle for non-memory ops; memory ops take 3 cycles plus extra WAIT cycles; stall is combinational.
module stage4_mem #(
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] regB_rd_data,
    input  logic [4:0]        reg_wr_addr,
    input  logic              alu_zero,
    input  logic              alu_not_zero,
    input  logic              alu_greater,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              reg_write,
    input  logic              mem_to_reg,
    input  logic              branch_eq,
    input  logic              branch_ne,
    input  logic              branch_gt,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ready,
    output logic              stall,
    output logic              pc_src,
    output logic              if_flush,
    output logic              mem_err,
    output logic [DATA_W-1:0] mem_rd_data_wb,
    output logic [DATA_W-1:0] alu_result_wb,
    output logic [4:0]        reg_wr_addr_wb,
    output logic              reg_write_wb,
    output logic              mem_to_reg_wb
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] cap_q, cap_d;
    logic              abort_q, abort_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rd_wb_q, rd_wb_d;
    logic [DATA_W-1:0] res_wb_q, res_wb_d;
    logic [4:0]        wa_wb_q, wa_wb_d;
    logic              rw_wb_q, rw_wb_d;
    logic              m2r_wb_q, m2r_wb_d;

    logic access, aligned, timeout;

    assign access  = mem_read | mem_write;
    assign aligned = (alu_result[1:0] == 2'b00);
    assign timeout = (cnt_q == CW'(MAX_WAIT - 1));

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (access && aligned)         state_d = WAIT;
            WAIT:    if (dmem_ready || timeout)     state_d = DONE;
            DONE:                                   state_d = IDLE;
            default:                                state_d = IDLE;
        endcase
    end

    // Stall is forced low while reset is asserted so upstream is never frozen by stale inputs.
    always_comb begin
        stall    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        case (state_q)
            IDLE: stall = rstb & access & aligned;
            WAIT: begin
                stall    = rstb;
                dmem_req = 1'b1;
                dmem_we  = mem_write;
            end
            default: ;
        endcase
        pc_src = ~stall & ((branch_eq & alu_zero) | (branch_ne & alu_not_zero) |
                           (branch_gt & alu_greater));
    end

    assign if_flush   = pc_src;
    assign dmem_addr  = alu_result;
    assign dmem_wdata = regB_rd_data;

    always_comb begin
        cnt_d    = '0;
        cap_d    = cap_q;
        abort_d  = abort_q;
        err_d    = err_q;
        rd_wb_d  = rd_wb_q;
        res_wb_d = res_wb_q;
        wa_wb_d  = wa_wb_q;
        rw_wb_d  = rw_wb_q;
        m2r_wb_d = m2r_wb_q;
        case (state_q)
            IDLE: begin
                if (access && (!aligned || (mem_read && mem_write))) err_d = 1'b1;
                if (access && aligned) begin
                    rw_wb_d  = 1'b0;
                    m2r_wb_d = 1'b0;
                    abort_d  = 1'b0;
                end else begin
                    rd_wb_d  = '0;
                    res_wb_d = alu_result;
                    wa_wb_d  = reg_wr_addr;
                    rw_wb_d  = reg_write & ~access;
                    m2r_wb_d = mem_to_reg;
                end
            end
            WAIT: begin
                rw_wb_d  = 1'b0;
                m2r_wb_d = 1'b0;
                if (dmem_ready) begin
                    cap_d   = mem_write ? '0 : dmem_rdata;
                    abort_d = 1'b0;
                end else if (timeout) begin
                    cap_d   = '0;
                    abort_d = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                rd_wb_d  = cap_q;
                res_wb_d = alu_result;
                wa_wb_d  = reg_wr_addr;
                rw_wb_d  = reg_write & ~abort_q;
                m2r_wb_d = mem_to_reg;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cnt_q    <= '0;
            cap_q    <= '0;
            abort_q  <= 1'b0;
            err_q    <= 1'b0;
            rd_wb_q  <= '0;
            res_wb_q <= '0;
            wa_wb_q  <= '0;
            rw_wb_q  <= 1'b0;
            m2r_wb_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            cap_q    <= cap_d;
            abort_q  <= abort_d;
            err_q    <= err_d;
            rd_wb_q  <= rd_wb_d;
            res_wb_q <= res_wb_d;
            wa_wb_q  <= wa_wb_d;
            rw_wb_q  <= rw_wb_d;
            m2r_wb_q <= m2r_wb_d;
        end
    end

    assign mem_err        = err_q;
    assign mem_rd_data_wb = rd_wb_q;
    assign alu_result_wb  = res_wb_q;
    assign reg_wr_addr_wb = wa_wb_q;
    assign reg_write_wb   = rw_wb_q;
    assign mem_to_reg_wb  = m2r_wb_q;

endmodule

// File: tb/tb_stage4_mem.sv
// Directed bench for stage4_mem: vector table for single-cycle ops/branches, hand sequences for memory accesses.
module tb_stage4_mem;

    logic        clk = 1'b0;
    logic        rstb;
    logic [31:0] alu_result, regB_rd_data, dmem_addr, dmem_wdata, dmem_rdata;
    logic [31:0] mem_rd_data_wb, alu_result_wb;
    logic [4:0]  reg_wr_addr, reg_wr_addr_wb;
    logic alu_zero, alu_not_zero, alu_greater, mem_read, mem_write, reg_write, mem_to_reg;
    logic branch_eq, branch_ne, branch_gt, dmem_req, dmem_we, dmem_ready;
    logic stall, pc_src, if_flush, mem_err, reg_write_wb, mem_to_reg_wb;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    stage4_mem #(.DATA_W(32), .MAX_WAIT(15)) dut (
        .clk(clk), .rstb(rstb), .alu_result(alu_result), .regB_rd_data(regB_rd_data),
        .reg_wr_addr(reg_wr_addr), .alu_zero(alu_zero), .alu_not_zero(alu_not_zero),
        .alu_greater(alu_greater), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .branch_eq(branch_eq),
        .branch_ne(branch_ne), .branch_gt(branch_gt), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_ready(dmem_ready), .stall(stall), .pc_src(pc_src), .if_flush(if_flush),
        .mem_err(mem_err), .mem_rd_data_wb(mem_rd_data_wb), .alu_result_wb(alu_result_wb),
        .reg_wr_addr_wb(reg_wr_addr_wb), .reg_write_wb(reg_write_wb),
        .mem_to_reg_wb(mem_to_reg_wb)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  wa;
        logic        z, nz, gt, rw, m2r, beq, bne, bgt;
        logic        exp_pc;
    } vec_t;

    vec_t tv[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic nop_inputs();
        alu_result = '0; regB_rd_data = '0; reg_wr_addr = '0;
        alu_zero = 1'b0; alu_not_zero = 1'b0; alu_greater = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0; mem_to_reg = 1'b0;
        branch_eq = 1'b0; branch_ne = 1'b0; branch_gt = 1'b0;
    endtask

    // Called just after a rising edge; returns just after the edge that loads MEM/WB.
    task automatic do_access(input logic [31:0] addr, input logic [31:0] wdata,
                             input logic rd, input logic wr, input logic [4:0] wa,
                             input int rdy_after, input logic [31:0] rdata,
                             input int exp_req, input int exp_stall, input logic exp_rw,
                             input logic [31:0] exp_rd, input logic exp_err);
        int  nreq = 0;
        int  nst  = 0;
        bit  done = 0;
        nop_inputs();
        alu_result = addr; regB_rd_data = wdata; reg_wr_addr = wa;
        mem_read = rd; mem_write = wr; reg_write = rd; mem_to_reg = rd;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (dmem_req) begin
                nreq++;
                chk("req_addr", dmem_addr, addr);
                chk("req_wdata", dmem_wdata, wdata);
                chk("req_we", 32'(dmem_we), 32'(wr));
                chk("bubble_rw", 32'(reg_write_wb), 32'd0);
                if (rdy_after != 0 && nreq == rdy_after) begin
                    dmem_ready = 1'b1;
                    dmem_rdata = rdata;
                end
            end else begin
                dmem_ready = 1'b0;
                dmem_rdata = '0;
            end
            if (stall) nst++;
            else       done = 1;
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL access_bound: stall still high after 40 cycles, required low");
        end
        chk("req_cycles", 32'(nreq), 32'(exp_req));
        chk("stall_cycles", 32'(nst), 32'(exp_stall));
        @(posedge clk); #1;
        chk("wb_rdata", mem_rd_data_wb, exp_rd);
        chk("wb_rw", 32'(reg_write_wb), 32'(exp_rw));
        chk("wb_wa", 32'(reg_wr_addr_wb), 32'(wa));
        chk("wb_res", alu_result_wb, addr);
        chk("mem_err", 32'(mem_err), 32'(exp_err));
        nop_inputs();
    endtask

    initial begin
        //           res           wa     z     nz    gt    rw    m2r   beq   bne   bgt   pc
        tv[0] = '{32'h0000_0010, 5'd5,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[1] = '{32'h0000_0000, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tv[2] = '{32'h0000_0004, 5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tv[3] = '{32'h0000_0008, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tv[4] = '{32'h0000_0000, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[5] = '{32'h0000_0003, 5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tv[6] = '{32'hFFFF_FFFF, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tv[7] = '{32'h0000_0055, 5'd31, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        rstb = 1'b0; dmem_ready = 1'b0; dmem_rdata = '0;
        nop_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_err", 32'(mem_err), 32'd0);
        chk("rst_res_wb", alu_result_wb, 32'd0);
        chk("rst_rw_wb", 32'(reg_write_wb), 32'd0);
        rstb = 1'b1;

        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            nop_inputs();
            alu_result = tv[i].res; reg_wr_addr = tv[i].wa;
            alu_zero = tv[i].z; alu_not_zero = tv[i].nz; alu_greater = tv[i].gt;
            reg_write = tv[i].rw; mem_to_reg = tv[i].m2r;
            branch_eq = tv[i].beq; branch_ne = tv[i].bne; branch_gt = tv[i].bgt;
            #2;
            chk($sformatf("v%0d_pc_src", i), 32'(pc_src), 32'(tv[i].exp_pc));
            chk($sformatf("v%0d_if_flush", i), 32'(if_flush), 32'(tv[i].exp_pc));
            chk($sformatf("v%0d_stall", i), 32'(stall), 32'd0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_res_wb", i), alu_result_wb, tv[i].res);
            chk($sformatf("v%0d_wa_wb", i), 32'(reg_wr_addr_wb), 32'(tv[i].wa));
            chk($sformatf("v%0d_rw_wb", i), 32'(reg_write_wb), 32'(tv[i].rw));
            chk($sformatf("v%0d_m2r_wb", i), 32'(mem_to_reg_wb), 32'(tv[i].m2r));
        end
        nop_inputs();

        // Load, ready in first WAIT cycle.
        do_access(32'h100, 32'h0, 1'b1, 1'b0, 5'd7, 1, 32'hDEAD_BEEF, 1, 2, 1'b1, 32'hDEAD_BEEF, 1'b0);
        chk("load_m2r_wb", 32'(mem_to_reg_wb), 32'd1);
        // Store, ready after 4 WAIT cycles.
        do_access(32'h40, 32'h1234, 1'b0, 1'b1, 5'd3, 4, 32'hFFFF_FFFF, 4, 5, 1'b0, 32'h0, 1'b0);

        // Misaligned load: no request, no stall, error.
        nop_inputs();
        alu_result = 32'h102; reg_wr_addr = 5'd9; mem_read = 1'b1; reg_write = 1'b1; mem_to_reg = 1'b1;
        #2;
        chk("misal_stall", 32'(stall), 32'd0);
        chk("misal_req", 32'(dmem_req), 32'd0);
        @(posedge clk); #1;
        chk("misal_err", 32'(mem_err), 32'd1);
        chk("misal_rw_wb", 32'(reg_write_wb), 32'd0);
        chk("misal_res_wb", alu_result_wb, 32'h102);
        nop_inputs();

        // Load that never completes: abort after 15 WAIT cycles.
        do_access(32'h200, 32'h0, 1'b1, 1'b0, 5'd4, 0, 32'h0, 15, 16, 1'b0, 32'h0, 1'b1);
        // Pipe resumes with a plain ALU op.
        alu_result = 32'h77; reg_wr_addr = 5'd2; reg_write = 1'b1;
        @(posedge clk); #1;
        chk("resume_res_wb", alu_result_wb, 32'h77);
        chk("resume_rw_wb", 32'(reg_write_wb), 32'd1);
        nop_inputs();

        // Reset asserted in the middle of a WAIT.
        alu_result = 32'h300; reg_wr_addr = 5'd6; mem_read = 1'b1; reg_write = 1'b1; mem_to_reg = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_rst_req", 32'(dmem_req), 32'd1);
        rstb = 1'b0;
        #1;
        chk("midrst_req", 32'(dmem_req), 32'd0);
        chk("midrst_stall", 32'(stall), 32'd0);
        chk("midrst_err", 32'(mem_err), 32'd0);
        chk("midrst_rw_wb", 32'(reg_write_wb), 32'd0);
        chk("midrst_res_wb", alu_result_wb, 32'd0);
        @(posedge clk); #1;
        rstb = 1'b1;
        #2;
        chk("post_rst_idle_stall", 32'(stall), 32'd1);
        chk("post_rst_idle_req", 32'(dmem_req), 32'd0);
        @(posedge clk); #1;
        chk("post_rst_wait_req", 32'(dmem_req), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
